img_frame_generator: RTL and testbench
======================================

Name: img_frame_generator

Overview:
- Transmitter end of the img stream protocol (row_first/row_last/col_first/col_last/de/user/data/valid under cke).
- Converts an AXI4-Stream video source (tuser = SOF, tlast = EOL, tvalid/tready backpressure) into a well-formed img frame.
- Pads malformed lines and frames, and appends de-low blank lines after each frame.
- Sits in front of img_blk_buffer, img_line_buffer and other img pipelines, replacing the master model in hardware.

Parameters:
- USER_WIDTH, 0, tuser side-band width beyond bit0 (SOF); 0 = none.
- DATA_WIDTH, 24, pixel data width.
- X_WIDTH, 12, column counter / param_width width.
- Y_WIDTH, 12, row counter / param_height width.
- PAD_VALUE, {DATA_WIDTH{1'b0}}, data driven on padded pixels.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous reset, active low.
- cke  in  1  clock enable; when 0 all state and outputs hold and s_axi4s_tready=0.
- enable  in  1  start/keep generating frames.
- busy  out  1  high from frame start through last blank line.
- param_width  in  X_WIDTH  columns per line, minimum 2.
- param_height  in  Y_WIDTH  active lines per frame, minimum 2.
- param_y_blank  in  Y_WIDTH  de-low lines appended per frame, may be 0.
- s_axi4s_tuser  in  USER_BITS  bit0 = SOF.
- s_axi4s_tlast  in  1  end of line.
- s_axi4s_tdata  in  DATA_WIDTH  pixel.
- s_axi4s_tvalid  in  1  beat valid.
- s_axi4s_tready  out  1  beat accepted when tvalid & tready & cke.
- m_img_row_first  out  1  first row.
- m_img_row_last  out  1  last active row.
- m_img_col_first  out  1  first column.
- m_img_col_last  out  1  last column.
- m_img_de  out  1  active pixel.
- m_img_user  out  USER_BITS  tuser of pixel; 0 on pad/blank.
- m_img_data  out  DATA_WIDTH  pixel, PAD_VALUE on pad, 0 on blank.
- m_img_valid  out  1  output beat qualifier.
- err_sof  out  1  sticky: premature SOF seen; cleared at reset.
- err_eol  out  1  sticky: early or late tlast seen; cleared at reset.

Behaviour:
- Reset values:
  - All m_img_* outputs = 0.
  - busy = 0; err_* = 0; state = IDLE.
- Output timing:
  - All outputs registered; one beat emitted per cke cycle with m_img_valid=1.
  - Latency = 1 cycle from accepted beat to its m_img output.
  - m_img_valid=0 when no beat is produced (input starved).
- States: IDLE, WAIT_SOF, ACTIVE, PAD, BLANK. Counters x, y, and blank-line counter.
- IDLE:
  - tready=0.
  - enable=1 -> WAIT_SOF.
- WAIT_SOF:
  - tready=1; beats without SOF are discarded, no output.
  - SOF beat -> latch params, emit (0,0) with row_first, col_first, de; then ACTIVE at x=1; busy=1.
- ACTIVE (tready=1): each accepted beat emits pixel (x,y), de=1.
  - Flags: col_first=(x==0), col_last=(x==width-1), row_first=(y==0), row_last=(y==height-1).
  - Normal line end: tlast at x==width-1 -> x=0, y+1.
  - Early tlast (x<width-1): emit the pixel, set err_eol, then PAD the rest of the line.
  - Missing tlast at x==width-1: emit the pixel, set err_eol, then discard beats until tlast (no output, tready=1). The beat carrying tlast is also discarded.
  - Last pixel of line height-1 -> BLANK, or WAIT_SOF / IDLE if param_y_blank=0.
- Premature SOF at any position other than (0,0) in ACTIVE:
  - Beat is not accepted (tready drops combinationally on tuser[0]); err_sof set.
  - PAD completes the frame: remaining pixels with de=1, data=PAD_VALUE, correct flags.
  - Then BLANK; the held SOF beat starts the next frame.
- PAD:
  - tready=0; one pad pixel per cke cycle.
  - Resumes ACTIVE at next line start, or BLANK / WAIT_SOF after the final row.
- BLANK:
  - param_y_blank lines of width beats each.
  - de=0, row_first=row_last=0, col_first/col_last asserted at line edges, valid=1.
  - At end: enable=1 -> WAIT_SOF, else IDLE with busy=0.
- enable deassert mid-frame: current frame, including pad and blank, completes first.
- Parameter changes take effect only at SOF latch.
- Async reset mid-frame: immediate return to reset values; downstream sees the frame truncated.

Optional Feature:
- Macro: JELLY_IMG_FRAME_GENERATOR_ERR_CNT_EN.
- Defined: adds outputs err_sof_count and err_eol_count, 16 bits each, saturating, incremented once per error event and cleared at reset.
- Undefined: ports and counters absent; only the sticky flags exist.

Decomposition:
- Package img_frame_generator_pkg: state_t enum (IDLE, WAIT_SOF, ACTIVE, PAD, BLANK) and a flag-struct typedef for row/col/de.
- One sub-module, img_frame_generator_pos: x/y position counter with width/height compare, producing first/last flags. Used by ACTIVE, PAD and BLANK.

Test Plan:
- Well-formed 8x4 frame, param_y_blank=2, continuous tvalid -> 32 de=1 beats with correct flags, then 16 de=0 beats; err_*=0; latency 1 cycle.
- Random tvalid gaps and cke toggling on 8x4 -> identical de=1 sequence; m_img_valid low only on gaps; frozen while cke=0.
- tlast at x=4 on row 1 (width 8) -> pixels 5..7 of row 1 padded with PAD_VALUE; err_eol=1; row 2 continues normally.
- No tlast at x=7 on row 0; tlast arrives 3 beats later -> those 3 beats dropped, err_eol=1, row 1 aligned.
- SOF at (3,2) of 8x4 frame -> remaining 13 pixels padded, blank lines emitted, new frame starts with the held beat; err_sof=1.
- reset_n asserted during row 2 -> all outputs 0 asynchronously; after release plus enable, waits for SOF and emits a clean frame.

Source files
------------

// File: rtl/img_frame_generator_pkg.sv
// Shared types for img_frame_generator.
//   state_t     : frame generator FSM states
//   img_flags_t : row/col boundary flags plus data-enable of one output beat
//   sat_inc16   : saturating increment for the optional error counters
package img_frame_generator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    PAD,
    BLANK
  } state_t;

  typedef struct packed {
    logic row_first;
    logic row_last;
    logic col_first;
    logic col_last;
    logic de;
  } img_flags_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/img_frame_generator_pos.sv
// x/y position counter for img_frame_generator.
// Ports:
//   clk, reset_n, cke : clock, async active-low reset, clock enable
//   clr               : return to (0,0); wins over inc
//   inc               : advance one pixel, wrapping x at width-1 into y+1
//   width, height     : line length / line count compared against
//   col_first/col_last/row_first/row_last : position flags of the current (x,y)
module img_frame_generator_pos #(
  parameter int X_WIDTH = 12,
  parameter int Y_WIDTH = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cke,
  input  logic               clr,
  input  logic               inc,
  input  logic [X_WIDTH-1:0] width,
  input  logic [Y_WIDTH-1:0] height,
  output logic               col_first,
  output logic               col_last,
  output logic               row_first,
  output logic               row_last
);

  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;

  assign col_first = (x == '0);
  assign col_last  = (x == width - X_WIDTH'(1));
  assign row_first = (y == '0);
  assign row_last  = (y == height - Y_WIDTH'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (cke) begin
      if (clr) begin
        x <= '0;
        y <= '0;
      end else if (inc) begin
        if (col_last) begin
          x <= '0;
          y <= y + Y_WIDTH'(1);
        end else begin
          x <= x + X_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/img_frame_generator.sv
// AXI4-Stream video to img stream frame generator.
// Turns an AXI4-Stream source (tuser[0]=SOF, tlast=EOL) into well-formed img
// frames: short lines and truncated frames are padded with PAD_VALUE, over-long
// lines are trimmed, and param_y_blank de-low lines follow every frame.
// Ports:
//   clk, reset_n, cke       : clock, async active-low reset, clock enable
//   enable / busy           : run request / frame in progress (through blanking)
//   param_width/height/y_blank : frame geometry, latched at SOF
//   s_axi4s_*               : AXI4-Stream input (tready drops on a premature SOF)
//   m_img_*                 : registered img stream output, 1-cycle latency
//   err_sof / err_eol       : sticky premature-SOF / bad-tlast flags
// Optional build macro JELLY_IMG_FRAME_GENERATOR_ERR_CNT_EN adds saturating
// 16-bit err_sof_count / err_eol_count outputs.
module img_frame_generator
  import img_frame_generator_pkg::*;
#(
  parameter int                    USER_WIDTH = 0,
  parameter int                    DATA_WIDTH = 24,
  parameter int                    X_WIDTH    = 12,
  parameter int                    Y_WIDTH    = 12,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b0}},
  localparam int                   USER_BITS  = USER_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cke,
  input  logic                  enable,
  output logic                  busy,
  input  logic [X_WIDTH-1:0]    param_width,
  input  logic [Y_WIDTH-1:0]    param_height,
  input  logic [Y_WIDTH-1:0]    param_y_blank,
  input  logic [USER_BITS-1:0]  s_axi4s_tuser,
  input  logic                  s_axi4s_tlast,
  input  logic [DATA_WIDTH-1:0] s_axi4s_tdata,
  input  logic                  s_axi4s_tvalid,
  output logic                  s_axi4s_tready,
  output logic                  m_img_row_first,
  output logic                  m_img_row_last,
  output logic                  m_img_col_first,
  output logic                  m_img_col_last,
  output logic                  m_img_de,
  output logic [USER_BITS-1:0]  m_img_user,
  output logic [DATA_WIDTH-1:0] m_img_data,
  output logic                  m_img_valid,
  output logic                  err_sof,
  output logic                  err_eol
`ifdef JELLY_IMG_FRAME_GENERATOR_ERR_CNT_EN
  ,
  output logic [15:0]           err_sof_count,
  output logic [15:0]           err_eol_count
`endif
);

  state_t             state, state_n;
  logic [X_WIDTH-1:0] p_w;
  logic [Y_WIDTH-1:0] p_h, p_blank;
  logic               drop, drop_n;       // trimming an over-long line until tlast
  logic               pad_all, pad_all_n; // premature SOF: pad to end of frame

  logic               emit, pos_inc, pos_clr, latch, set_sof, set_eol;
  img_flags_t         flags_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [USER_BITS-1:0]  user_n;
  state_t             frame_done;

  logic [X_WIDTH-1:0] pos_w;
  logic [Y_WIDTH-1:0] pos_h;
  logic               pos_cf, pos_cl, pos_rf, pos_rl;
  img_flags_t         pos_flags;

  // Before SOF the new geometry is compared directly so pixel (0,0) is
  // flagged against the parameters being latched; BLANK counts blank lines.
  assign pos_w = (state == WAIT_SOF) ? param_width : p_w;
  assign pos_h = (state == WAIT_SOF) ? param_height :
                 (state == BLANK)    ? p_blank      : p_h;

  img_frame_generator_pos #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_pos (
    .clk       (clk),
    .reset_n   (reset_n),
    .cke       (cke),
    .clr       (pos_clr),
    .inc       (pos_inc),
    .width     (pos_w),
    .height    (pos_h),
    .col_first (pos_cf),
    .col_last  (pos_cl),
    .row_first (pos_rf),
    .row_last  (pos_rl)
  );

  assign pos_flags  = '{row_first: pos_rf, row_last: pos_rl,
                        col_first: pos_cf, col_last: pos_cl, de: 1'b1};
  assign frame_done = (p_blank != '0) ? BLANK : (enable ? WAIT_SOF : IDLE);

  always_comb begin
    state_n        = state;
    drop_n         = drop;
    pad_all_n      = pad_all;
    s_axi4s_tready = 1'b0;
    emit           = 1'b0;
    pos_inc        = 1'b0;
    pos_clr        = 1'b0;
    latch          = 1'b0;
    set_sof        = 1'b0;
    set_eol        = 1'b0;
    flags_n        = '0;
    data_n         = '0;
    user_n         = '0;
    if (cke) begin
      case (state)
        IDLE: begin
          if (enable) state_n = WAIT_SOF;
        end
        WAIT_SOF: begin
          s_axi4s_tready = 1'b1;
          if (s_axi4s_tvalid && s_axi4s_tuser[0]) begin
            latch     = 1'b1;
            emit      = 1'b1;
            pos_inc   = 1'b1;
            flags_n   = pos_flags;
            data_n    = s_axi4s_tdata;
            user_n    = s_axi4s_tuser;
            drop_n    = 1'b0;
            pad_all_n = 1'b0;
            state_n   = ACTIVE;
            if (s_axi4s_tlast) begin
              set_eol = 1'b1;
              state_n = PAD;
            end
          end else if (!enable) begin
            state_n = IDLE;
          end
        end
        ACTIVE: begin
          // A SOF inside the frame is held off; it will open the next frame.
          s_axi4s_tready = !s_axi4s_tuser[0];
          if (s_axi4s_tvalid) begin
            if (s_axi4s_tuser[0]) begin
              set_sof   = 1'b1;
              drop_n    = 1'b0;
              pad_all_n = 1'b1;
              state_n   = PAD;
            end else if (drop) begin
              if (s_axi4s_tlast) drop_n = 1'b0;
            end else begin
              emit    = 1'b1;
              pos_inc = 1'b1;
              flags_n = pos_flags;
              data_n  = s_axi4s_tdata;
              user_n  = s_axi4s_tuser;
              if (pos_cl) begin
                if (!s_axi4s_tlast) set_eol = 1'b1;
                if (pos_rl) begin
                  pos_clr = 1'b1;
                  state_n = frame_done;
                end else begin
                  drop_n = !s_axi4s_tlast;
                end
              end else if (s_axi4s_tlast) begin
                set_eol = 1'b1;
                state_n = PAD;
              end
            end
          end
        end
        PAD: begin
          emit    = 1'b1;
          pos_inc = 1'b1;
          flags_n = pos_flags;
          data_n  = PAD_VALUE;
          if (pos_cl) begin
            if (pos_rl) begin
              pos_clr   = 1'b1;
              pad_all_n = 1'b0;
              state_n   = frame_done;
            end else if (!pad_all) begin
              state_n = ACTIVE;
            end
          end
        end
        BLANK: begin
          emit    = 1'b1;
          pos_inc = 1'b1;
          flags_n = '{row_first: 1'b0, row_last: 1'b0,
                      col_first: pos_cf, col_last: pos_cl, de: 1'b0};
          if (pos_cl && pos_rl) begin
            pos_clr = 1'b1;
            state_n = enable ? WAIT_SOF : IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      drop    <= 1'b0;
      pad_all <= 1'b0;
      p_w     <= '0;
      p_h     <= '0;
      p_blank <= '0;
      busy    <= 1'b0;
      err_sof <= 1'b0;
      err_eol <= 1'b0;
    end else if (cke) begin
      state   <= state_n;
      drop    <= drop_n;
      pad_all <= pad_all_n;
      busy    <= (state_n == ACTIVE) || (state_n == PAD) || (state_n == BLANK);
      if (latch) begin
        p_w     <= param_width;
        p_h     <= param_height;
        p_blank <= param_y_blank;
      end
      if (set_sof) err_sof <= 1'b1;
      if (set_eol) err_eol <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_img_valid     <= 1'b0;
      m_img_row_first <= 1'b0;
      m_img_row_last  <= 1'b0;
      m_img_col_first <= 1'b0;
      m_img_col_last  <= 1'b0;
      m_img_de        <= 1'b0;
      m_img_user      <= '0;
      m_img_data      <= '0;
    end else if (cke) begin
      m_img_valid     <= emit;
      m_img_row_first <= flags_n.row_first;
      m_img_row_last  <= flags_n.row_last;
      m_img_col_first <= flags_n.col_first;
      m_img_col_last  <= flags_n.col_last;
      m_img_de        <= flags_n.de;
      m_img_user      <= user_n;
      m_img_data      <= data_n;
    end
  end

`ifdef JELLY_IMG_FRAME_GENERATOR_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_sof_count <= '0;
      err_eol_count <= '0;
    end else if (cke) begin
      if (set_sof) err_sof_count <= sat_inc16(err_sof_count);
      if (set_eol) err_eol_count <= sat_inc16(err_eol_count);
    end
  end
`endif

endmodule

// File: tb/tb_img_frame_generator.sv
// Scoreboard bench for img_frame_generator on an 8x4 frame with 2 blank lines.
module tb_img_frame_generator;
  localparam int              DW   = 24;
  localparam int              XW   = 12;
  localparam int              YW   = 12;
  localparam int              UB   = 1;
  localparam logic [DW-1:0]   PADV = 24'hABCDEF;

  logic          clk, reset_n, cke, enable, busy;
  logic [XW-1:0] param_width;
  logic [YW-1:0] param_height, param_y_blank;
  logic [UB-1:0] s_axi4s_tuser;
  logic          s_axi4s_tlast, s_axi4s_tvalid, s_axi4s_tready;
  logic [DW-1:0] s_axi4s_tdata;
  logic          m_img_row_first, m_img_row_last, m_img_col_first, m_img_col_last;
  logic          m_img_de, m_img_valid, err_sof, err_eol;
  logic [UB-1:0] m_img_user;
  logic [DW-1:0] m_img_data;
`ifdef JELLY_IMG_FRAME_GENERATOR_ERR_CNT_EN
  logic [15:0]   err_sof_count, err_eol_count;
`endif

  img_frame_generator #(
    .USER_WIDTH (0),
    .DATA_WIDTH (DW),
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW),
    .PAD_VALUE  (PADV)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cke             (cke),
    .enable          (enable),
    .busy            (busy),
    .param_width     (param_width),
    .param_height    (param_height),
    .param_y_blank   (param_y_blank),
    .s_axi4s_tuser   (s_axi4s_tuser),
    .s_axi4s_tlast   (s_axi4s_tlast),
    .s_axi4s_tdata   (s_axi4s_tdata),
    .s_axi4s_tvalid  (s_axi4s_tvalid),
    .s_axi4s_tready  (s_axi4s_tready),
    .m_img_row_first (m_img_row_first),
    .m_img_row_last  (m_img_row_last),
    .m_img_col_first (m_img_col_first),
    .m_img_col_last  (m_img_col_last),
    .m_img_de        (m_img_de),
    .m_img_user      (m_img_user),
    .m_img_data      (m_img_data),
    .m_img_valid     (m_img_valid),
    .err_sof         (err_sof),
    .err_eol         (err_eol)
`ifdef JELLY_IMG_FRAME_GENERATOR_ERR_CNT_EN
    ,
    .err_sof_count   (err_sof_count),
    .err_eol_count   (err_eol_count)
`endif
  );

  typedef struct packed {
    logic          rf, rl, cf, cl, de;
    logic [UB-1:0] user;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    cke_rand = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cke = 1'b1;
    forever begin
      @(negedge clk);
      cke = cke_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.rf = m_img_row_first; b.rl = m_img_row_last;
    b.cf = m_img_col_first; b.cl = m_img_col_last;
    b.de = m_img_de; b.user = m_img_user; b.data = m_img_data;
    return b;
  endfunction

  // Monitor: pops on every emitted beat; outputs must hold while cke=0.
  logic  mon_ck, mon_rs, mon_prev_v;
  beat_t mon_cur, mon_prev, mon_e;
  initial begin
    mon_prev   = '0;
    mon_prev_v = 1'b0;
    forever begin
      @(posedge clk);
      mon_ck = cke;
      mon_rs = reset_n;
      #1;
      mon_cur = cur_beat();
      if (mon_rs && reset_n) begin
        if (mon_ck) begin
          if (m_img_valid) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_beat actual=%0h required=none", mon_cur);
            end else begin
              mon_e = exp_q.pop_front();
              chk("beat", 64'(mon_cur), 64'(mon_e));
            end
          end
        end else begin
          chk("frozen", 64'({mon_prev_v, mon_cur}), 64'({mon_prev_v, mon_prev}));
          chk("frozen_valid", 64'(m_img_valid), 64'(mon_prev_v));
        end
      end
      mon_prev   = mon_cur;
      mon_prev_v = m_img_valid;
    end
  end

  function automatic logic [DW-1:0] pix(input int f, input int x, input int y);
    return DW'(f * 4096 + y * 256 + x);
  endfunction

  task automatic push_px(input int x, input int y, input logic [DW-1:0] d, input logic u);
    beat_t b;
    b.rf = (y == 0); b.rl = (y == 3); b.cf = (x == 0); b.cl = (x == 7);
    b.de = 1'b1; b.user = u; b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic push_blank();
    beat_t b;
    for (int l = 0; l < 2; l++)
      for (int x = 0; x < 8; x++) begin
        b = '0;
        b.cf = (x == 0); b.cl = (x == 7);
        exp_q.push_back(b);
      end
  endtask

  task automatic push_frame(input int f);
    for (int i = 0; i < 32; i++) push_px(i % 8, i / 8, pix(f, i % 8, i / 8), i == 0);
    push_blank();
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic sof, input logic last, input logic [DW-1:0] d);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    s_axi4s_tuser = sof; s_axi4s_tlast = last; s_axi4s_tdata = d; s_axi4s_tvalid = 1'b1;
    while (!ok) begin
      #4;
      ok = s_axi4s_tready && cke;
      @(negedge clk);
      n++;
      if (!ok && n > 500) begin
        $display("FAIL send_timeout actual=stalled required=accepted");
        $fatal(1, "input beat never accepted");
      end
    end
    s_axi4s_tvalid = 1'b0; s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0;
  endtask

  task automatic send_range(input int f, input int lo, input int hi, input bit gaps);
    for (int i = lo; i <= hi; i++) begin
      send(i == 0, (i % 8) == 7, pix(f, i % 8, i / 8));
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0;
    param_width = 12'd8; param_height = 12'd4; param_y_blank = 12'd2;
    s_axi4s_tuser = '0; s_axi4s_tlast = 1'b0; s_axi4s_tdata = '0; s_axi4s_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(m_img_valid), 64'd0);
    chk("rst_beat", 64'(cur_beat()), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'({err_sof, err_eol}), 64'd0);
    chk("rst_tready", 64'(s_axi4s_tready), 64'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (2) @(negedge clk);

    // Well-formed frame; two leading non-SOF beats must be discarded.
    push_frame(1);
    send(1'b0, 1'b0, 24'h111111);
    send(1'b0, 1'b1, 24'h222222);
    send_range(1, 0, 0, 0);
    chk("latency", 64'({m_img_valid, m_img_row_first, m_img_col_first, m_img_de}), 64'hF);
    chk("busy_active", 64'(busy), 64'd1);
    send_range(1, 1, 31, 0);
    wait_drain();
    chk("t1_err", 64'({err_sof, err_eol}), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_wait_sof_ready", 64'(s_axi4s_tready), 64'd1);

    // Same frame with random input gaps and cke toggling.
    push_frame(2);
    cke_rand = 1;
    send_range(2, 0, 31, 1);
    wait_drain();
    cke_rand = 0;
    @(negedge clk);
    chk("t2_err", 64'({err_sof, err_eol}), 64'd0);

    // Early tlast at x=4 of row 1: x=5..7 padded.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i / 8 == 1 && i % 8 > 4) push_px(i % 8, 1, PADV, 1'b0);
      else push_px(i % 8, i / 8, pix(3, i % 8, i / 8), i == 0);
    end
    push_blank();
    send_range(3, 0, 11, 0);
    send(1'b0, 1'b1, pix(3, 4, 1));
    send_range(3, 16, 31, 0);
    wait_drain();
    chk("t3_err", 64'({err_sof, err_eol}), 64'd1);

    // Missing tlast on row 0; three extra beats dropped.
    do_reset();
    push_frame(4);
    send_range(4, 0, 6, 0);
    send(1'b0, 1'b0, pix(4, 7, 0));
    send(1'b0, 1'b0, 24'h555555);
    send(1'b0, 1'b0, 24'h666666);
    send(1'b0, 1'b1, 24'h777777);
    send_range(4, 8, 31, 0);
    wait_drain();
    chk("t4_err", 64'({err_sof, err_eol}), 64'd1);

    // Premature SOF at (3,2): 13 pad pixels, blanking, then held SOF opens frame 6.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      if (i < 19) push_px(i % 8, i / 8, pix(5, i % 8, i / 8), i == 0);
      else push_px(i % 8, i / 8, PADV, 1'b0);
    end
    push_blank();
    push_frame(6);
    send_range(5, 0, 18, 0);
    send_range(6, 0, 31, 0);
    wait_drain();
    chk("t5_err", 64'({err_sof, err_eol}), 64'd2);

    // Async reset during row 2, then a clean frame with enable dropped mid-frame.
    for (int i = 0; i < 19; i++) push_px(i % 8, i / 8, pix(7, i % 8, i / 8), i == 0);
    send_range(7, 0, 18, 0);
    #2;
    enable  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(m_img_valid), 64'd0);
    chk("t6_rst_beat", 64'(cur_beat()), 64'd0);
    chk("t6_rst_busy_err", 64'({busy, err_sof, err_eol}), 64'd0);
    chk("t6_queue", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    push_frame(8);
    send_range(8, 0, 19, 0);
    enable = 1'b0;
    send_range(8, 20, 31, 0);
    wait_drain();
    chk("t6_busy_end", 64'(busy), 64'd0);
    chk("t6_idle_tready", 64'(s_axi4s_tready), 64'd0);
    chk("t6_err", 64'({err_sof, err_eol}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
